// File: rtl/ej5_bool_funcs.sv
// ej5_bool_funcs: four fixed 3-input functions, as combinational SOP outputs
// and as NAND/NOR-only versions captured in flip-flops.
module ej5_bool_funcs (
    input  logic clk,
    input  logic reset,
    input  logic A,
    input  logic B,
    input  logic C,
    output logic f,
    output logic g,
    output logic h,
    output logic l,
    output logic fb,
    output logic gb,
    output logic hb,
    output logic lb
);
    function automatic logic nd(input logic a, input logic b);
        return ~(a & b);
    endfunction
    function automatic logic nr(input logic a, input logic b);
        return ~(a | b);
    endfunction
    function automatic logic xnd(input logic a, input logic b);
        logic t;
        t = nd(a, b);
        return nd(nd(a, t), nd(b, t));
    endfunction

    logic [3:0] bool_d, bool_q;
    logic       na, nb, nc;

    assign f = (A & B) | C;
    assign g = A ^ B ^ C;
    assign h = (A & B) | (A & C) | (B & C);
    assign l = (~A & ~B) | (A & C);

    // Gate-only forms: inverters are a NAND/NOR with both inputs tied together.
    always_comb begin
        na        = nd(A, A);
        nb        = nd(B, B);
        nc        = nd(C, C);
        bool_d[3] = nd(nd(A, B), nc);
        bool_d[2] = xnd(xnd(A, B), C);
        bool_d[1] = nd(nd(A, B), nd(C, nd(na, nb)));
        bool_d[0] = nr(nr(nr(A, B), nr(na, nc)), nr(nr(A, B), nr(na, nc)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bool_q <= 4'b0000;
        else        bool_q <= bool_d;
    end

    assign {fb, gb, hb, lb} = bool_q;
endmodule

// File: tb/tb_ej5_bool_funcs.sv
// tb_ej5_bool_funcs: directed checks of the SOP and registered gate-only
// outputs of ej5_bool_funcs against a hand-written truth table.
module tb_ej5_bool_funcs;
    logic clk = 1'b0;
    logic reset, A, B, C;
    logic f, g, h, l, fb, gb, hb, lb;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [3:0] row [8] = '{4'b0001, 4'b1101, 4'b0100, 4'b1010,
                            4'b0100, 4'b1011, 4'b1010, 4'b1111};
    logic [2:0] prev;

    ej5_bool_funcs dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .C(C),
        .f(f), .g(g), .h(h), .l(l),
        .fb(fb), .gb(gb), .hb(hb), .lb(lb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        {A, B, C} = 3'b111;
        #2;
        chk("rst_reg", {fb, gb, hb, lb}, 4'b0000);
        chk("rst_comb", {f, g, h, l}, 4'b1111);
        @(posedge clk); #1;
        chk("rst_hold", {fb, gb, hb, lb}, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            {A, B, C} = 3'(n);
            #1;
            chk($sformatf("sweep_comb%0d", n), {f, g, h, l}, row[n]);
            @(posedge clk); #1;
            chk($sformatf("sweep_reg%0d", n), {fb, gb, hb, lb}, row[n]);
        end
        @(negedge clk);
        {A, B, C} = 3'b000;
        @(posedge clk); #1;
        {A, B, C} = 3'b111;
        #1;
        chk("lat_comb", {f, g, h, l}, 4'b1111);
        chk("lat_reg_old", {fb, gb, hb, lb}, 4'b0001);
        @(negedge clk);
        chk("lat_reg_hold", {fb, gb, hb, lb}, 4'b0001);
        @(posedge clk); #1;
        chk("lat_reg_new", {fb, gb, hb, lb}, 4'b1111);
        @(negedge clk);
        {A, B, C} = 3'b101;
        @(posedge clk); #1;
        chk("mid_pre", {fb, gb, hb, lb}, 4'b1011);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_async", {fb, gb, hb, lb}, 4'b0000);
        chk("mid_comb", {f, g, h, l}, 4'b1011);
        @(posedge clk); #1;
        chk("mid_hold", {fb, gb, hb, lb}, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rel", {fb, gb, hb, lb}, 4'b0000);
        @(posedge clk); #1;
        chk("mid_reload", {fb, gb, hb, lb}, 4'b1011);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            prev = 3'($urandom_range(7));
            {A, B, C} = prev;
            #1;
            chk($sformatf("eq_comb%0d", i), {f, g, h, l}, row[prev]);
            @(posedge clk); #1;
            chk($sformatf("eq_reg%0d", i), {fb, gb, hb, lb}, row[prev]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
